// File: rtl/urv_dm_wb_bridge_pkg.sv
// Shared definitions for the uRV data-memory to Wishbone bridge.
// Holds the FSM state encoding, the default watchdog limit and a counter-width helper.
package urv_dm_wb_bridge_pkg;

  typedef enum logic [1:0] {
    DmbIdle,
    DmbIssue,
    DmbWait
  } dmb_state_e;

  localparam int unsigned DmbTimeoutDefault = 255;

  // Watchdog counter width; a disabled watchdog still gets a 1-bit counter.
  function automatic int unsigned dmb_cnt_width(input int unsigned timeout_cycles);
    return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/urv_dm_wb_bridge.sv
// uRV data-memory responder: runs each CPU load/store as one pipelined single-beat
// Wishbone B4 cycle, with optional posted writes and a bus timeout watchdog.
module urv_dm_wb_bridge
  import urv_dm_wb_bridge_pkg::*;
#(
  parameter int unsigned g_posted_writes  = 1,
  parameter int unsigned g_timeout_cycles = DmbTimeoutDefault
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_bus_error_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  localparam int unsigned      CntW   = dmb_cnt_width(g_timeout_cycles);
  localparam logic [CntW-1:0]  CntMax = CntW'(g_timeout_cycles);
  localparam logic [CntW-1:0]  CntHit = CntW'(g_timeout_cycles - 1);
  localparam bit               Posted = (g_posted_writes != 0);
  localparam bit               WdogEn = (g_timeout_cycles != 0);

  dmb_state_e       state_q, state_d;
  logic [31:2]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [3:0]       sel_q, sel_d;
  logic             we_q, we_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             load_done_q, load_done_d;
  logic             store_done_q, store_done_d;
  logic             bus_err_q, bus_err_d;
  logic [31:0]      data_l_q, data_l_d;

  logic             timeout_hit;
  logic             finish;
  logic             failed;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^dm_addr_i[1:0];

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    bus_err_d    = 1'b0;
    data_l_d     = data_l_q;
    finish       = 1'b0;
    failed       = 1'b0;
    timeout_hit  = WdogEn && (cnt_q == CntHit);

    unique case (state_q)
      DmbIdle: begin
        if (dm_load_i || dm_store_i) begin
          adr_d   = dm_addr_i[31:2];
          dat_d   = dm_data_s_i;
          sel_d   = dm_data_select_i;
          we_d    = !dm_load_i;  // load wins when both strobes are high
          cnt_d   = '0;
          state_d = DmbIssue;
          if (!dm_load_i && Posted) store_done_d = 1'b1;
        end
      end
      DmbIssue: begin
        if (wb_ack_i || wb_err_i || timeout_hit) begin
          finish = 1'b1;
        end else if (!wb_stall_i) begin
          state_d = DmbWait;
        end
      end
      DmbWait: begin
        if (wb_ack_i || wb_err_i || timeout_hit) finish = 1'b1;
      end
      default: state_d = DmbIdle;
    endcase

    if (state_q != DmbIdle && cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);

    if (finish) begin
      state_d = DmbIdle;
      failed  = !wb_ack_i;  // an ack beats both err and watchdog expiry
      if (!we_q) begin
        load_done_d = 1'b1;
        data_l_d    = wb_ack_i ? wb_dat_i : '0;
        bus_err_d   = failed;
      end else begin
        // Posted stores were already completed; only the error is reported late.
        store_done_d = !Posted;
        bus_err_d    = failed;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= DmbIdle;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      bus_err_q    <= 1'b0;
      data_l_q     <= '0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      bus_err_q    <= bus_err_d;
      data_l_q     <= data_l_d;
    end
  end

  assign dm_ready_o      = (state_q == DmbIdle);
  assign dm_data_l_o     = data_l_q;
  assign dm_load_done_o  = load_done_q;
  assign dm_store_done_o = store_done_q;
  assign dm_bus_error_o  = bus_err_q;
  assign wb_cyc_o        = (state_q != DmbIdle);
  assign wb_stb_o        = (state_q == DmbIssue);
  assign wb_we_o         = we_q;
  assign wb_adr_o        = {adr_q, 2'b00};
  assign wb_dat_o        = dat_q;
  assign wb_sel_o        = sel_q;

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// Scoreboard bench for urv_dm_wb_bridge: dut0 posts writes, dut1 waits for the bus
// and has an 8-cycle watchdog. Both share the Wishbone responder inputs.
module tb_urv_dm_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dm_addr, dm_data_s;
  logic [3:0]  dm_sel;
  logic        dm_load[2], dm_store[2];
  logic [31:0] wb_dat;
  logic        wb_ack, wb_err, wb_stall;

  logic        ready[2], load_done[2], store_done[2], bus_err[2];
  logic        cyc[2], stb[2], we[2];
  logic [31:0] data_l[2], adr[2], dat[2];
  logic [3:0]  sel[2];

  typedef struct packed {
    logic        ld;
    logic        st;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  urv_dm_wb_bridge #(.g_posted_writes(1), .g_timeout_cycles(255)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s), .dm_data_select_i(dm_sel),
    .dm_load_i(dm_load[0]), .dm_store_i(dm_store[0]), .dm_ready_o(ready[0]),
    .dm_data_l_o(data_l[0]), .dm_load_done_o(load_done[0]),
    .dm_store_done_o(store_done[0]), .dm_bus_error_o(bus_err[0]),
    .wb_cyc_o(cyc[0]), .wb_stb_o(stb[0]), .wb_we_o(we[0]), .wb_adr_o(adr[0]),
    .wb_dat_o(dat[0]), .wb_sel_o(sel[0]), .wb_dat_i(wb_dat),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_stall_i(wb_stall)
  );

  urv_dm_wb_bridge #(.g_posted_writes(0), .g_timeout_cycles(8)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s), .dm_data_select_i(dm_sel),
    .dm_load_i(dm_load[1]), .dm_store_i(dm_store[1]), .dm_ready_o(ready[1]),
    .dm_data_l_o(data_l[1]), .dm_load_done_o(load_done[1]),
    .dm_store_done_o(store_done[1]), .dm_bus_error_o(bus_err[1]),
    .wb_cyc_o(cyc[1]), .wb_stb_o(stb[1]), .wb_we_o(we[1]), .wb_adr_o(adr[1]),
    .wb_dat_o(dat[1]), .wb_sel_o(sel[1]), .wb_dat_i(wb_dat),
    .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_stall_i(wb_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic ld, input logic st, input logic err,
                      input logic [31:0] d);
    exp_t e;
    e = '{ld: ld, st: st, err: err, data: d};
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Monitor: every completion/error pulse must match the next queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic have;
    for (int i = 0; i < 2; i++) begin
      if (load_done[i] || store_done[i] || bus_err[i]) begin
        have = 1'b1;
        if (i == 0) begin
          if (q0.size() == 0) have = 1'b0;
          else e = q0.pop_front();
        end else begin
          if (q1.size() == 0) have = 1'b0;
          else e = q1.pop_front();
        end
        if (!have) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_resp dut%0d: got ld=%b st=%b err=%b, want no pulse",
                   i, load_done[i], store_done[i], bus_err[i]);
        end else begin
          chk($sformatf("resp%0d_load_done", i), 32'(load_done[i]), 32'(e.ld));
          chk($sformatf("resp%0d_store_done", i), 32'(store_done[i]), 32'(e.st));
          chk($sformatf("resp%0d_bus_error", i), 32'(bus_err[i]), 32'(e.err));
          if (e.ld) chk($sformatf("resp%0d_load_data", i), data_l[i], e.data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    dm_addr = '0; dm_data_s = '0; dm_sel = '0;
    dm_load[0] = 1'b0; dm_load[1] = 1'b0; dm_store[0] = 1'b0; dm_store[1] = 1'b0;
    wb_dat = '0; wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_ready", i), 32'(ready[i]), 32'd1);
      chk($sformatf("rst%0d_cyc", i), 32'(cyc[i]), 32'd0);
      chk($sformatf("rst%0d_stb", i), 32'(stb[i]), 32'd0);
      chk($sformatf("rst%0d_adr", i), adr[i], 32'd0);
      chk($sformatf("rst%0d_data_l", i), data_l[i], 32'd0);
      chk($sformatf("rst%0d_pulses", i),
          32'({load_done[i], store_done[i], bus_err[i]}), 32'd0);
    end
    rst_n = 1'b1;

    // Zero-wait load
    dm_addr = 32'h0000_1004; dm_sel = 4'b1111; dm_load[0] = 1'b1;
    push(0, 1, 0, 0, 32'hCAFE_BABE);
    tick();
    dm_load[0] = 1'b0;
    chk("t1_stb", 32'(stb[0]), 32'd1);
    chk("t1_adr", adr[0], 32'h0000_1004);
    chk("t1_we", 32'(we[0]), 32'd0);
    chk("t1_ready_busy", 32'(ready[0]), 32'd0);
    chk("t1_done_early", 32'(load_done[0]), 32'd0);
    wb_ack = 1'b1; wb_dat = 32'hCAFE_BABE;
    tick();
    wb_ack = 1'b0;
    chk("t1_load_done", 32'(load_done[0]), 32'd1);
    chk("t1_data", data_l[0], 32'hCAFE_BABE);
    chk("t1_ready_back", 32'(ready[0]), 32'd1);

    // Stalled posted store
    dm_addr = 32'h0000_2002; dm_data_s = 32'hBEEF_BEEF; dm_sel = 4'b1100;
    dm_store[0] = 1'b1; wb_stall = 1'b1;
    push(0, 0, 1, 0, 32'd0);
    tick();
    dm_store[0] = 1'b0;
    chk("t2_store_done_n1", 32'(store_done[0]), 32'd1);
    chk("t2_sel", 32'(sel[0]), 32'hC);
    chk("t2_adr", adr[0], 32'h0000_2000);
    chk("t2_dat", dat[0], 32'hBEEF_BEEF);
    chk("t2_we", 32'(we[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        tick();
        chk("t2_single_done", 32'(store_done[0]), 32'd0);
      end
      wb_stall = (k < 3);
      chk("t2_stb_held", 32'(stb[0]), 32'd1);
      chk("t2_ready_busy", 32'(ready[0]), 32'd0);
    end
    tick();
    chk("t2_wait_stb", 32'(stb[0]), 32'd0);
    chk("t2_wait_cyc", 32'(cyc[0]), 32'd1);
    chk("t2_wait_ready", 32'(ready[0]), 32'd0);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    chk("t2_ready_back", 32'(ready[0]), 32'd1);
    chk("t2_cyc_drop", 32'(cyc[0]), 32'd0);
    chk("t2_data_hold", data_l[0], 32'hCAFE_BABE);

    // Load terminated by err
    dm_addr = 32'h0000_3000; dm_sel = 4'b1111; dm_load[0] = 1'b1;
    push(0, 1, 0, 1, 32'd0);
    tick();
    dm_load[0] = 1'b0;
    wb_err = 1'b1; wb_dat = 32'h1234_5678;
    tick();
    wb_err = 1'b0;
    chk("t3_load_done", 32'(load_done[0]), 32'd1);
    chk("t3_bus_error", 32'(bus_err[0]), 32'd1);
    chk("t3_data_zero", data_l[0], 32'd0);

    // Posted store that later errors: done first, error alone afterwards
    dm_addr = 32'h0000_3010; dm_store[0] = 1'b1;
    push(0, 0, 1, 0, 32'd0);
    push(0, 0, 0, 1, 32'd0);
    tick();
    dm_store[0] = 1'b0;
    wb_err = 1'b1;
    tick();
    wb_err = 1'b0;
    chk("t3b_no_done", 32'(store_done[0]), 32'd0);
    chk("t3b_error", 32'(bus_err[0]), 32'd1);

    // Watchdog on non-posted store (dut1, 8 cycles)
    dm_addr = 32'h0000_4000; dm_data_s = 32'h0102_0304; dm_store[1] = 1'b1;
    push(1, 0, 1, 1, 32'd0);
    tick();
    dm_store[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      chk("t4_cyc_held", 32'(cyc[1]), 32'd1);
      chk("t4_no_done", 32'(store_done[1]), 32'd0);
    end
    tick();
    chk("t4_cyc_drop", 32'(cyc[1]), 32'd0);
    chk("t4_store_done", 32'(store_done[1]), 32'd1);
    chk("t4_error", 32'(bus_err[1]), 32'd1);
    chk("t4_ready", 32'(ready[1]), 32'd1);
    dm_addr = 32'h0000_4008; dm_load[1] = 1'b1;
    push(1, 1, 0, 0, 32'h55AA_55AA);
    tick();
    dm_load[1] = 1'b0;
    chk("t4_next_stb", 32'(stb[1]), 32'd1);
    chk("t4_next_adr", adr[1], 32'h0000_4008);
    wb_ack = 1'b1; wb_dat = 32'h55AA_55AA;
    tick();
    wb_ack = 1'b0;
    chk("t4_next_done", 32'(load_done[1]), 32'd1);

    // Ack in the expiry cycle wins over the watchdog
    dm_addr = 32'h0000_4100; dm_load[1] = 1'b1;
    push(1, 1, 0, 0, 32'h0BAD_F00D);
    tick();
    dm_load[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      chk("t4b_cyc_held", 32'(cyc[1]), 32'd1);
      if (k == 7) begin
        wb_ack = 1'b1; wb_dat = 32'h0BAD_F00D;
      end
    end
    tick();
    wb_ack = 1'b0;
    chk("t4b_done", 32'(load_done[1]), 32'd1);
    chk("t4b_no_error", 32'(bus_err[1]), 32'd0);
    chk("t4b_data", data_l[1], 32'h0BAD_F00D);

    // Reset in WAIT, then a stray ack
    dm_addr = 32'h0000_5000; dm_load[0] = 1'b1;
    tick();
    dm_load[0] = 1'b0;
    chk("t5_stb", 32'(stb[0]), 32'd1);
    tick();
    chk("t5_in_wait", 32'({cyc[0], stb[0]}), 32'b10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_cyc_drop", 32'(cyc[0]), 32'd0);
    chk("t5_no_done", 32'(load_done[0]), 32'd0);
    chk("t5_ready", 32'(ready[0]), 32'd1);
    wb_ack = 1'b1; wb_dat = 32'hFFFF_FFFF;
    tick();
    wb_ack = 1'b0;
    chk("t5_stray_done", 32'(load_done[0]), 32'd0);
    chk("t5_stray_err", 32'(bus_err[0]), 32'd0);
    chk("t5_stray_data", data_l[0], 32'd0);

    // Simultaneous strobes (load wins), then back-to-back load
    dm_addr = 32'h0000_6000; dm_data_s = 32'hDEAD_BEEF; dm_load[0] = 1'b1; dm_store[0] = 1'b1;
    push(0, 1, 0, 0, 32'h1111_2222);
    tick();
    dm_load[0] = 1'b0; dm_store[0] = 1'b0;
    chk("t6_read_only", 32'(we[0]), 32'd0);
    chk("t6_stb", 32'(stb[0]), 32'd1);
    chk("t6_no_store_done", 32'(store_done[0]), 32'd0);
    wb_ack = 1'b1; wb_dat = 32'h1111_2222;
    tick();
    wb_ack = 1'b0;
    chk("t6_done", 32'(load_done[0]), 32'd1);
    chk("t6_ready", 32'(ready[0]), 32'd1);
    dm_addr = 32'h0000_6004; dm_load[0] = 1'b1;
    push(0, 1, 0, 0, 32'h3333_4444);
    tick();
    dm_load[0] = 1'b0;
    chk("t6_b2b_stb", 32'(stb[0]), 32'd1);
    chk("t6_b2b_adr", adr[0], 32'h0000_6004);
    wb_ack = 1'b1; wb_dat = 32'h3333_4444;
    tick();
    wb_ack = 1'b0;
    chk("t6_b2b_done", 32'(load_done[0]), 32'd1);
    tick();
    tick();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
